// File: rtl/tone_pkg.sv
// Shared types and defaults for the tone clock divider.
// Optional build macro TONE_SYNC_EN (see tone_clk_div) changes nothing in this package.
package tone_pkg;

  localparam int DEF_CNT_W     = 27;
  localparam int DEF_DIV_RESET = 2;

  typedef logic [DEF_CNT_W-1:0] div_t;

  // What a channel does on the coming edge, derived from ch_en and act_div.
  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_SILENT = 2'd1,
    CH_RUN    = 2'd2
  } ch_mode_t;

  function automatic ch_mode_t classify_mode(input logic en, input logic div_zero);
    ch_mode_t m;
    m = CH_IDLE;
    if (en) m = div_zero ? CH_SILENT : CH_RUN;
    return m;
  endfunction

endpackage

// File: rtl/tone_div_ch.sv
// One divider channel: counter, shadow divide register and output toggle.
// With TONE_SYNC_EN defined, sync_in restarts the channel and applies any pending divide.
module tone_div_ch
  import tone_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DIV_RESET = DEF_DIV_RESET
) (
  input  logic             clk_in,
  input  logic             rst,
`ifdef TONE_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             ch_en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO     = '0;
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] pend_div;
  logic             pend_vld;
  ch_mode_t         mode;
  logic             boundary;

  // The compare against act_div-1 is what keeps cnt from ever wrapping.
  always_comb begin
    mode     = classify_mode(ch_en, act_div == ZERO);
    boundary = (mode == CH_RUN) && (cnt == act_div - ONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt      <= ZERO;
      act_div  <= DIV_INIT;
      pend_div <= DIV_INIT;
      pend_vld <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end
`ifdef TONE_SYNC_EN
    else if (sync_in) begin
      cnt     <= ZERO;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      if (div_load) begin
        act_div  <= div_value;
        pend_div <= div_value;
        pend_vld <= 1'b0;
      end else if (pend_vld) begin
        act_div  <= pend_div;
        pend_vld <= 1'b0;
      end
    end
`endif
    else begin
      if (div_load) pend_div <= div_value;
      case (mode)
        CH_RUN: begin
          if (boundary) begin
            cnt     <= ZERO;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
            // A load landing on the boundary beats an older pending value.
            if (div_load) begin
              act_div  <= div_value;
              pend_vld <= 1'b0;
            end else if (pend_vld) begin
              act_div  <= pend_div;
              pend_vld <= 1'b0;
            end
          end else begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
            if (div_load) pend_vld <= 1'b1;
          end
        end
        default: begin
          // Idle or silent: nothing to protect, so a load takes effect at once.
          cnt     <= ZERO;
          clk_out <= 1'b0;
          tick    <= 1'b0;
          if (div_load) begin
            act_div  <= div_value;
            pend_vld <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/tone_clk_div.sv
// N_CH-channel programmable tone clock divider, one channel per sounding voice.
// Define TONE_SYNC_EN to add sync_in, which restarts all channels phase-aligned.
module tone_clk_div
  import tone_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DIV_RESET = DEF_DIV_RESET
) (
  input  logic                  clk_in,
  input  logic                  rst,
`ifdef TONE_SYNC_EN
  input  logic                  sync_in,
`endif
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       div_load,
  input  logic [N_CH*CNT_W-1:0] div_value,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    tone_div_ch #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clk_in    (clk_in),
      .rst       (rst),
`ifdef TONE_SYNC_EN
      .sync_in   (sync_in),
`endif
      .ch_en     (ch_en[k]),
      .div_load  (div_load[k]),
      .div_value (div_value[k*CNT_W +: CNT_W]),
      .clk_out   (clk_out[k]),
      .tick      (tick[k])
    );
  end

endmodule

// File: tb/tb_tone_clk_div.sv
// Scoreboard bench for tone_clk_div: a cycle model pushes expected outputs, the DUT pops them.
module tb_tone_clk_div;

  localparam int N_CH  = 4;
  localparam int CNT_W = 27;

  logic                  clk_in = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH-1:0]       ch_en = '0;
  logic [N_CH-1:0]       div_load = '0;
  logic [N_CH*CNT_W-1:0] div_value = '0;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
`ifdef TONE_SYNC_EN
  logic                  sync_in = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  tone_clk_div #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_RESET(2)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
`ifdef TONE_SYNC_EN
    .sync_in   (sync_in),
`endif
    .ch_en     (ch_en),
    .div_load  (div_load),
    .div_value (div_value),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // Model state counts cycles remaining until the next toggle.
  int   m_left [N_CH];
  int   m_div  [N_CH];
  int   m_pend [N_CH];
  bit   m_pv   [N_CH];
  bit   m_clk  [N_CH];
  bit   m_tick [N_CH];
  int   ld_val [N_CH];

  logic [2*N_CH-1:0] exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  string tag = "init";

  task automatic model_edge();
    logic [2*N_CH-1:0] e;
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        m_div[c] = 2; m_left[c] = 2; m_pv[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end else if (!ch_en[c] || m_div[c] == 0) begin
        if (div_load[c]) begin m_div[c] = ld_val[c]; m_pv[c] = 0; end
        m_left[c] = m_div[c]; m_clk[c] = 0; m_tick[c] = 0;
      end else if (m_left[c] == 1) begin
        m_clk[c] = !m_clk[c]; m_tick[c] = 1;
        if (div_load[c]) begin m_div[c] = ld_val[c]; m_pv[c] = 0; end
        else if (m_pv[c]) begin m_div[c] = m_pend[c]; m_pv[c] = 0; end
        m_left[c] = m_div[c];
      end else begin
        m_left[c]--; m_tick[c] = 0;
        if (div_load[c]) begin m_pend[c] = ld_val[c]; m_pv[c] = 1; end
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      e[c]        = m_clk[c];
      e[N_CH + c] = m_tick[c];
    end
    exp_q.push_back(e);
  endtask

  task automatic check_output();
    logic [2*N_CH-1:0] e;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL %s: scoreboard empty, observed %h", tag, {tick, clk_out});
      return;
    end
    e = exp_q.pop_front();
    compared++;
    assert ({tick, clk_out} === e) else begin
      mismatched++;
      $error("[TB] FAIL %s: {tick,clk_out} observed %h expected %h", tag, {tick, clk_out}, e);
    end
  endtask

  task automatic apply_stimulus();
    for (int c = 0; c < N_CH; c++) div_value[c*CNT_W +: CNT_W] = CNT_W'(ld_val[c]);
    model_edge();
    @(posedge clk_in);
    #1;
    check_output();
    div_load = '0;
  endtask

  task automatic load(input int ch, input int v);
    ld_val[ch]   = v;
    div_load[ch] = 1'b1;
  endtask

  task automatic check_bit(input string name, input logic obs, input logic expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", name, obs, expv);
    end
  endtask

  initial begin
    for (int c = 0; c < N_CH; c++) begin
      ld_val[c] = 0; m_left[c] = 0; m_div[c] = 0; m_pend[c] = 0;
      m_pv[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
    end

    tag = "reset";
    rst = 1'b1;
    apply_stimulus();
    apply_stimulus();
    check_bit("reset_clk0", clk_out[0], 1'b0);
    check_bit("reset_tick0", tick[0], 1'b0);

    // Divide-by-2 default: toggles every 2 cycles.
    tag = "default_div2";
    rst = 1'b0;
    ch_en = 4'b0001;
    apply_stimulus(); check_bit("d2_e1_clk", clk_out[0], 1'b0); check_bit("d2_e1_tick", tick[0], 1'b0);
    apply_stimulus(); check_bit("d2_e2_clk", clk_out[0], 1'b1); check_bit("d2_e2_tick", tick[0], 1'b1);
    apply_stimulus(); check_bit("d2_e3_clk", clk_out[0], 1'b1); check_bit("d2_e3_tick", tick[0], 1'b0);
    apply_stimulus(); check_bit("d2_e4_clk", clk_out[0], 1'b0); check_bit("d2_e4_tick", tick[0], 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus();

    // ch1: div=3 loaded while idle, then div=5 mid-period.
    tag = "reload_3_to_5";
    load(1, 3);
    apply_stimulus();
    ch_en = 4'b0011;
    for (int i = 0; i < 4; i++) apply_stimulus();
    load(1, 5);
    for (int i = 0; i < 22; i++) apply_stimulus();

    // ch2: last of two loads wins, then a load on the boundary cycle.
    tag = "last_load_wins";
    load(2, 4);
    apply_stimulus();
    ch_en = 4'b0111;
    apply_stimulus();
    load(2, 7);
    apply_stimulus();
    load(2, 9);
    for (int i = 0; i < 30; i++) apply_stimulus();
    tag = "boundary_load";
    for (int i = 0; i < 20 && m_left[2] != 1; i++) apply_stimulus();
    if (m_left[2] != 1) begin
      mismatched++;
      $error("[TB] FAIL boundary_wait: no boundary within budget");
    end
    load(2, 6);
    for (int i = 0; i < 16; i++) apply_stimulus();

    // ch0 disabled while high, then re-enabled.
    tag = "disable_mid_high";
    for (int i = 0; i < 8 && !m_clk[0]; i++) apply_stimulus();
    check_bit("ch0_high_before_disable", clk_out[0], 1'b1);
    ch_en[0] = 1'b0;
    apply_stimulus();
    check_bit("ch0_low_after_disable", clk_out[0], 1'b0);
    apply_stimulus();
    ch_en[0] = 1'b1;
    apply_stimulus(); check_bit("reen_e1_clk", clk_out[0], 1'b0);
    apply_stimulus(); check_bit("reen_e2_clk", clk_out[0], 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus();

    // ch3: div=0 silent, then div=1 toggles every cycle.
    tag = "silent_then_div1";
    load(3, 0);
    apply_stimulus();
    ch_en[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus();
      check_bit("silent_clk3", clk_out[3], 1'b0);
      check_bit("silent_tick3", tick[3], 1'b0);
    end
    load(3, 1);
    apply_stimulus();
    check_bit("div1_load_clk3", clk_out[3], 1'b0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus();
      check_bit("div1_clk3", clk_out[3], (i % 2 == 0) ? 1'b1 : 1'b0);
      check_bit("div1_tick3", tick[3], 1'b1);
    end

    // Reset mid-run with a pending value on ch1.
    tag = "reset_drops_pending";
    load(1, 8);
    apply_stimulus();
    rst = 1'b1;
    apply_stimulus();
    check_bit("rst_clk1", clk_out[1], 1'b0);
    check_bit("rst_tick1", tick[1], 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) apply_stimulus();

    // Random mix of enables, loads and the odd reset.
    tag = "random";
    for (int i = 0; i < 80; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        ch_en[c] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 5) == 0) load(c, int'($urandom_range(0, 5)));
      end
      rst = ($urandom_range(0, 49) == 0);
      apply_stimulus();
    end
    rst = 1'b0;

    compared++;
    assert (exp_q.size() === 0) else begin
      mismatched++;
      $error("[TB] FAIL drain: observed %0d entries left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
